// File: rtl/link_motion_if.sv
// link_motion_if
//   Groups the frame-strobe/keycode inputs and the sprite-state outputs of
//   link_motion so the block and its environment connect through one bundle.
//   Clock and reset stay outside as plain ports.
//
//   Signals:
//     frame_clk    - vertical-sync-rate strobe, asynchronous to Clk
//     keycode      - current USB keycode (0x00 = none)
//     LinkX/LinkY  - top-left sprite position
//     LinkS        - sprite edge length (constant)
//     face_keycode - last valid direction keycode
//     moving       - 1 while the motion FSM is in WALK
//     walk_frame   - animation phase bit
//     tick         - one-Clk pulse per frame_clk rising edge
//     fsm_state    - raw motion FSM state (0 = IDLE, 1 = WALK), for checkers
//
//   Handshake: there is no valid/ready pair here. tick acts as a one-cycle
//   valid strobe with no back-pressure; keycode is consumed only in the tick
//   cycle and the position outputs carry the result from the next cycle on.
//
//   Modports: master = environment (drives frame_clk/keycode),
//             slave  = link_motion (drives the sprite state).
interface link_motion_if;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [9:0] LinkX;
   logic [9:0] LinkY;
   logic [9:0] LinkS;
   logic [7:0] face_keycode;
   logic       moving;
   logic       walk_frame;
   logic       tick;
   logic       fsm_state;

   modport master (
      output frame_clk, keycode,
      input  LinkX, LinkY, LinkS, face_keycode, moving, walk_frame, tick,
             fsm_state
   );

   modport slave (
      input  frame_clk, keycode,
      output LinkX, LinkY, LinkS, face_keycode, moving, walk_frame, tick,
             fsm_state
   );
endinterface

// File: rtl/link_motion.sv
// link_motion
//   Per-frame movement controller for Link's sprite. The frame strobe is
//   synchronised into Clk and edge-detected into a one-cycle tick; on each
//   tick the keycode is decoded and Link moves STEP pixels along one axis,
//   clamped to the play area. A two-state FSM (IDLE/WALK) tracks whether
//   Link is walking and drives the walk animation counter.
//
//   Ports:
//     Clk   - system clock, all state on the rising edge
//     Reset - asynchronous, active-high reset
//     bus   - link_motion_if.slave (frame_clk, keycode in; sprite state out)
module link_motion #(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 639,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479,
   parameter int SIZE     = 32,
   parameter int STEP     = 2,
   parameter int X_START  = 304,
   parameter int Y_START  = 224,
   parameter int ANIM_DIV = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   link_motion_if.slave  bus
);

   localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   // Clamp limits and step kept 11 bits wide so the compare sees the carry
   // out of LinkX+STEP and can never wrap.
   localparam logic [10:0] X_LIM    = 11'(X_MAX - SIZE + 1);
   localparam logic [10:0] Y_LIM    = 11'(Y_MAX - SIZE + 1);
   localparam logic [10:0] X_LO     = 11'(X_MIN + STEP);
   localparam logic [10:0] Y_LO     = 11'(Y_MIN + STEP);
   localparam logic [10:0] STEP11   = 11'(STEP);
   localparam logic [9:0]  STEP10   = 10'(STEP);
   localparam logic [CW-1:0] CNT_TOP = CW'(ANIM_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic          s1, s2, s3;
   logic          tick_q;
   logic [9:0]    x_q, x_nxt;
   logic [9:0]    y_q, y_nxt;
   logic [7:0]    face_q, face_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          wf_q, wf_nxt;

   logic          dir_up, dir_down, dir_left, dir_right, dir_valid;
   logic [10:0]   x_plus, y_plus;
   logic [9:0]    x_right, x_left, y_down, y_up;

   // Two-flop synchroniser plus history flop; tick is the registered rising
   // edge of the synchronised strobe.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         s1     <= bus.frame_clk;
         s2     <= s1;
         s3     <= s2;
         tick_q <= s2 & ~s3;
      end
   end

   assign dir_up    = (bus.keycode == 8'h1A);
   assign dir_down  = (bus.keycode == 8'h16);
   assign dir_left  = (bus.keycode == 8'h04);
   assign dir_right = (bus.keycode == 8'h07);
   assign dir_valid = dir_up | dir_down | dir_left | dir_right;

   // Candidate positions for each direction, already clamped.
   assign x_plus  = {1'b0, x_q} + STEP11;
   assign y_plus  = {1'b0, y_q} + STEP11;
   assign x_right = (x_plus > X_LIM) ? X_LIM[9:0] : x_plus[9:0];
   assign y_down  = (y_plus > Y_LIM) ? Y_LIM[9:0] : y_plus[9:0];
   assign x_left  = ({1'b0, x_q} < X_LO) ? X_MIN[9:0] : (x_q - STEP10);
   assign y_up    = ({1'b0, y_q} < Y_LO) ? Y_MIN[9:0] : (y_q - STEP10);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         x_q    <= 10'(X_START);
         y_q    <= 10'(Y_START);
         face_q <= 8'h16;
         cnt_q  <= '0;
         wf_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         x_q    <= x_nxt;
         y_q    <= y_nxt;
         face_q <= face_nxt;
         cnt_q  <= cnt_nxt;
         wf_q   <= wf_nxt;
      end
   end

   // Everything holds outside tick cycles; a tick either walks (move, face,
   // animate) or drops to IDLE and clears the animation.
   always_comb begin
      state_nxt = state;
      x_nxt     = x_q;
      y_nxt     = y_q;
      face_nxt  = face_q;
      cnt_nxt   = cnt_q;
      wf_nxt    = wf_q;
      if (tick_q) begin
         if (dir_valid) begin
            state_nxt = WALK;
            face_nxt  = bus.keycode;
            if (dir_up)         y_nxt = y_up;
            else if (dir_down)  y_nxt = y_down;
            else if (dir_left)  x_nxt = x_left;
            else                x_nxt = x_right;
            if (cnt_q == CNT_TOP) begin
               cnt_nxt = '0;
               wf_nxt  = ~wf_q;
            end else begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            wf_nxt    = 1'b0;
         end
      end
   end

   assign bus.LinkX        = x_q;
   assign bus.LinkY        = y_q;
   assign bus.LinkS        = 10'(SIZE);
   assign bus.face_keycode = face_q;
   assign bus.moving       = (state == WALK);
   assign bus.walk_frame   = wf_q;
   assign bus.tick         = tick_q;
   assign bus.fsm_state    = state;

endmodule

// File: tb/tb_link_motion.sv
// tb_link_motion
//   Directed bench for link_motion. Three instances share one stimulus:
//   default parameters, Y_START=1 (top edge) and X_START=606 (right edge).
//   Expected sprite states are queued when a frame is driven and checked
//   the cycle after the tick, when the DUT presents the result.
module tb_link_motion;

   logic       Clk;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;

   int tests;
   int fails;
   int sel;

   logic [29:0] exp_q[$];

   link_motion_if if_main ();
   link_motion_if if_top ();
   link_motion_if if_edge ();

   assign if_main.frame_clk = frame_clk;
   assign if_main.keycode   = keycode;
   assign if_top.frame_clk  = frame_clk;
   assign if_top.keycode    = keycode;
   assign if_edge.frame_clk = frame_clk;
   assign if_edge.keycode   = keycode;

   link_motion u_main (.Clk(Clk), .Reset(Reset), .bus(if_main.slave));
   link_motion #(.Y_START(1)) u_top (.Clk(Clk), .Reset(Reset), .bus(if_top.slave));
   link_motion #(.X_START(606)) u_edge (.Clk(Clk), .Reset(Reset), .bus(if_edge.slave));

   // clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [29:0] pack(input int x, input int y, input logic [7:0] f,
                                        input logic m, input logic w);
      logic [9:0] xv;
      logic [9:0] yv;
      xv = 10'(x);
      yv = 10'(y);
      return {xv, yv, f, m, w};
   endfunction

   function automatic logic [29:0] observed();
      case (sel)
         1:       return {if_top.LinkX, if_top.LinkY, if_top.face_keycode, if_top.moving, if_top.walk_frame};
         2:       return {if_edge.LinkX, if_edge.LinkY, if_edge.face_keycode, if_edge.moving, if_edge.walk_frame};
         default: return {if_main.LinkX, if_main.LinkY, if_main.face_keycode, if_main.moving, if_main.walk_frame};
      endcase
   endfunction

   function automatic logic tick_obs();
      case (sel)
         1:       return if_top.tick;
         2:       return if_edge.tick;
         default: return if_main.tick;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: one frame_clk pulse, tick checked on each of the 4 following
   // edges, result popped from the scoreboard after the update edge
   task automatic frame_pulse(input logic [7:0] kc);
      logic [29:0] exp;
      @(negedge Clk);
      keycode   = kc;
      frame_clk = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge Clk);
         #1;
         chk($sformatf("tick_edge%0d", e), {29'b0, tick_obs()}, {29'b0, (e == 3)});
      end
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty observed=%h expected=none", observed());
      end else begin
         exp = exp_q.pop_front();
         chk("sprite_state", observed(), exp);
      end
      @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset     = 1'b1;
      frame_clk = 1'b0;
      keycode   = 8'h00;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      sel       = 0;
      Reset     = 1'b1;
      frame_clk = 1'b0;
      keycode   = 8'h00;
      repeat (2) @(posedge Clk);
      #1;
      chk("reset_state_main", observed(), pack(304, 224, 8'h16, 1'b0, 1'b0));
      chk("reset_links", {20'b0, if_main.LinkS}, 30'd32);
      chk("reset_tick", {29'b0, tick_obs()}, 30'd0);
      @(negedge Clk);
      Reset = 1'b0;

      // one move, then reset while the second tick is high (mid-move)
      exp_q.push_back(pack(306, 224, 8'h07, 1'b1, 1'b0));
      frame_pulse(8'h07);
      @(negedge Clk);
      keycode   = 8'h07;
      frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_reset_state", observed(), pack(304, 224, 8'h16, 1'b0, 1'b0));
      chk("async_reset_tick", {29'b0, tick_obs()}, 30'd0);
      chk("async_reset_links", {20'b0, if_main.LinkS}, 30'd32);
      frame_clk = 1'b0;
      keycode   = 8'h00;
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk);
         #1;
         chk("no_tick_after_reset", {29'b0, tick_obs()}, 30'd0);
      end
      chk("post_reset_state", observed(), pack(304, 224, 8'h16, 1'b0, 1'b0));

      // right held for 5 frames
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back(pack(304 + 2 * i, 224, 8'h07, 1'b1, 1'b0));
         frame_pulse(8'h07);
      end

      // left for 8 frames toggles walk_frame on the 8th, then one idle frame
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back(pack(304 - 2 * i, 224, 8'h04, 1'b1, (i == 8)));
         frame_pulse(8'h04);
      end
      exp_q.push_back(pack(288, 224, 8'h04, 1'b0, 1'b0));
      frame_pulse(8'h00);

      // keycode glitches between ticks are ignored; only the tick value counts
      do_reset();
      keycode = 8'h07;
      repeat (3) @(negedge Clk);
      keycode = 8'h2C;
      repeat (3) @(negedge Clk);
      keycode = 8'h07;
      repeat (3) @(negedge Clk);
      #1;
      chk("glitch_hold", observed(), pack(304, 224, 8'h16, 1'b0, 1'b0));
      exp_q.push_back(pack(304, 226, 8'h16, 1'b1, 1'b0));
      frame_pulse(8'h16);

      // top edge: Y starts at 1, up clamps at 0 with no wrap
      do_reset();
      sel = 1;
      exp_q.push_back(pack(304, 0, 8'h1A, 1'b1, 1'b0));
      frame_pulse(8'h1A);
      exp_q.push_back(pack(304, 0, 8'h1A, 1'b1, 1'b0));
      frame_pulse(8'h1A);

      // right edge: X starts at 606, clamps at 608
      do_reset();
      sel = 2;
      exp_q.push_back(pack(608, 224, 8'h07, 1'b1, 1'b0));
      frame_pulse(8'h07);
      exp_q.push_back(pack(608, 224, 8'h07, 1'b1, 1'b0));
      frame_pulse(8'h07);

      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
